// File: rtl/imem_trace_decoder.sv
// imem_trace_decoder: passive fetch monitor decoding instruction words into encoder fields; optional TRACE_FILTER_DUP_EN suppresses repeated-PC captures
module imem_trace_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             imem_req_valid,
  input  logic [31:0]      imem_req_addr,
  input  logic [31:0]      imem_resp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [1:0]       out_opcode_rep,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic             out_funct7,
  output logic [11:0]      out_imm,
  output logic             out_illegal,
  output logic             overflow,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] drop_count
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [11:0] imm;
    logic        ill;
  } entry_t;
  logic             cap;
  logic             s1_vld_q;
  logic [31:0]      s1_pc_q, s1_data_q, d;
  logic [1:0]       op;
  logic             r_ill, i_ill, b_ill;
  entry_t           dec_d, head;
  entry_t           mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             empty, full, pop, push, drop;
  logic             ovf_q;
  logic [CNT_W-1:0] fetch_q, drop_q;
`ifdef TRACE_FILTER_DUP_EN
  logic [31:0] last_pc_q;
  logic        last_vld_q;
  assign cap = imem_req_valid && !(last_vld_q && imem_req_addr == last_pc_q);
  // remember the most recently captured PC so stall/reset-hold repeats are skipped
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
    end else if (cap) begin
      last_pc_q  <= imem_req_addr;
      last_vld_q <= 1'b1;
    end
`else
  assign cap = imem_req_valid;
`endif
  // capture stage: register the fetch PC and word
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_pc_q   <= '0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q <= cap;
      if (cap) begin
        s1_pc_q   <= imem_req_addr;
        s1_data_q <= imem_resp_data;
      end
    end
  assign d  = s1_data_q;
  assign op = d[6:0] == 7'b0110011 ? 2'd0 :
              d[6:0] == 7'b0010011 ? 2'd1 :
              d[6:0] == 7'b1100011 ? 2'd2 : 2'd3;
  assign r_ill = !(d[31:25] == 7'h00 || (d[31:25] == 7'h20 && (d[14:12] == 3'd0 || d[14:12] == 3'd5)));
  assign i_ill = d[14:12] == 3'd1 ? |d[31:25] :
                 d[14:12] == 3'd5 ? (d[31] || |d[29:25]) : 1'b0;
  assign b_ill = d[14:12] == 3'd2 || d[14:12] == 3'd3 || d[8];
  // decode the captured word into encoder representative fields
  always_comb begin
    dec_d.pc  = s1_pc_q;
    dec_d.op  = op;
    dec_d.rs1 = d[19:15];
    dec_d.f3  = d[14:12];
    dec_d.rs2 = op == 2'd1 ? 5'd0 : d[24:20];
    dec_d.rd  = op == 2'd2 ? 5'd0 : d[11:7];
    dec_d.f7  = (op == 2'd0 || op == 2'd3) ? d[30] : 1'b0;
    dec_d.imm = op == 2'd1 ? d[31:20] :
                op == 2'd2 ? {d[31], d[7], d[30:25], d[11:8]} : 12'd0;
    dec_d.ill = op == 2'd0 ? r_ill : op == 2'd1 ? i_ill : op == 2'd2 ? b_ill : 1'b1;
  end
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && out_ready;
  assign push  = s1_vld_q && (!full || pop);
  assign drop  = s1_vld_q && full && !pop;
  // FIFO storage; contents are don't-care until the write pointer covers them
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= dec_d;
  // FIFO pointers, sticky overflow and saturating statistics
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      fetch_q <= '0;
      drop_q  <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop) rd_q <= rd_q + (AW+1)'(1);
      if (drop) ovf_q <= 1'b1;
      if (cap && !(&fetch_q)) fetch_q <= fetch_q + CNT_W'(1);
      if (drop && !(&drop_q)) drop_q <= drop_q + CNT_W'(1);
    end
  assign head           = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign out_valid      = !empty;
  assign out_pc         = head.pc;
  assign out_opcode_rep = head.op;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_rd         = head.rd;
  assign out_funct3     = head.f3;
  assign out_funct7     = head.f7;
  assign out_imm        = head.imm;
  assign out_illegal    = head.ill;
  assign overflow       = ovf_q;
  assign fetch_count    = fetch_q;
  assign drop_count     = drop_q;
endmodule

// File: tb/tb_imem_trace_decoder.sv
// tb_imem_trace_decoder: table-driven decode vectors plus FIFO, reset and filter sequences
module tb_imem_trace_decoder;
  localparam int CW = 4;
  logic          clk = 1'b0, reset_n = 1'b0, imem_req_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]   imem_req_addr = '0, imem_resp_data = '0;
  logic          out_valid, out_funct7, out_illegal, overflow;
  logic [31:0]   out_pc;
  logic [1:0]    out_opcode_rep;
  logic [4:0]    out_rs1, out_rs2, out_rd;
  logic [2:0]    out_funct3;
  logic [11:0]   out_imm;
  logic [CW-1:0] fetch_count, drop_count;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  imem_trace_decoder #(.DEPTH(4), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode_rep(out_opcode_rep), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_illegal(out_illegal), .overflow(overflow),
    .fetch_count(fetch_count), .drop_count(drop_count)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [11:0] imm;
    logic        ill;
  } vec_t;
  vec_t tv[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] act_fields();
    return {out_opcode_rep, out_rs1, out_rs2, out_rd, out_funct3, out_funct7, out_imm, out_illegal};
  endfunction

  function automatic logic [33:0] exp_fields(input int i);
    return {tv[i].op, tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].f3, tv[i].f7, tv[i].imm, tv[i].ill};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    imem_req_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int n, idx, cnt;
    tv[0]  = '{32'h00B50533, 2'd0, 5'd10, 5'd11, 5'd10, 3'd0, 1'b0, 12'h000, 1'b0};
    tv[1]  = '{32'h40B50533, 2'd0, 5'd10, 5'd11, 5'd10, 3'd0, 1'b1, 12'h000, 1'b0};
    tv[2]  = '{32'h40B51533, 2'd0, 5'd10, 5'd11, 5'd10, 3'd1, 1'b1, 12'h000, 1'b1};
    tv[3]  = '{32'h02B50533, 2'd0, 5'd10, 5'd11, 5'd10, 3'd0, 1'b0, 12'h000, 1'b1};
    tv[4]  = '{32'h4020D093, 2'd1, 5'd1,  5'd0,  5'd1,  3'd5, 1'b0, 12'h402, 1'b0};
    tv[5]  = '{32'h4420D093, 2'd1, 5'd1,  5'd0,  5'd1,  3'd5, 1'b0, 12'h442, 1'b1};
    tv[6]  = '{32'h00209093, 2'd1, 5'd1,  5'd0,  5'd1,  3'd1, 1'b0, 12'h002, 1'b0};
    tv[7]  = '{32'h02209093, 2'd1, 5'd1,  5'd0,  5'd1,  3'd1, 1'b0, 12'h022, 1'b1};
    tv[8]  = '{32'hFFF00293, 2'd1, 5'd0,  5'd0,  5'd5,  3'd0, 1'b0, 12'hFFF, 1'b0};
    tv[9]  = '{32'h7E419EE3, 2'd2, 5'd3,  5'd4,  5'd0,  3'd1, 1'b0, 12'h7FE, 1'b0};
    tv[10] = '{32'h7E41AEE3, 2'd2, 5'd3,  5'd4,  5'd0,  3'd2, 1'b0, 12'h7FE, 1'b1};
    tv[11] = '{32'h7E419FE3, 2'd2, 5'd3,  5'd4,  5'd0,  3'd1, 1'b0, 12'h7FF, 1'b1};
    tv[12] = '{32'hFE419EE3, 2'd2, 5'd3,  5'd4,  5'd0,  3'd1, 1'b0, 12'hFFE, 1'b0};
    tv[13] = '{32'h000012B7, 2'd3, 5'd0,  5'd0,  5'd5,  3'd1, 1'b0, 12'h000, 1'b1};

    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_fields", {out_pc, act_fields()}, 64'd0);
    chk("rst_stats", {overflow, fetch_count, drop_count}, 64'd0);

    @(negedge clk);
    imem_req_valid = 1'b1; imem_req_addr = 32'h0; imem_resp_data = tv[0].data;
    @(negedge clk);
    imem_req_valid = 1'b0;
    chk("lat_edge1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_edge2", 64'(out_valid), 64'd1);
    chk("vec0", 64'(act_fields()), 64'(exp_fields(0)));
    chk("vec0_pc", 64'(out_pc), 64'h0);
    @(negedge clk);
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_fields", {out_pc[29:0], act_fields()}, {30'h0, exp_fields(0)});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop_empty", 64'(out_valid), 64'd0);
    chk("fetch1", 64'(fetch_count), 64'd1);

    for (int i = 1; i < 14; i++) begin
      @(negedge clk);
      imem_req_valid = 1'b1; imem_req_addr = 32'h100 + 4 * i; imem_resp_data = tv[i].data;
      @(negedge clk);
      imem_req_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 5) begin @(negedge clk); n++; end
      chk($sformatf("vec%0d", i), 64'(act_fields()), 64'(exp_fields(i)));
      chk($sformatf("vec%0d_pc", i), 64'(out_pc), 64'(32'h100 + 4 * i));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end

    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      imem_req_valid = 1'b1; imem_req_addr = 32'h200 + 4 * i; imem_resp_data = tv[0].data;
    end
    @(negedge clk);
    imem_req_valid = 1'b0;
    chk("ovf_fetch", 64'(fetch_count), 64'd6);
    chk("ovf_drop", 64'(drop_count), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("ovf_order%0d", j), {31'd0, out_valid, out_pc}, {31'd0, 1'b1, (j < 4 ? 32'h200 + 4 * j : 32'h214)});
      @(negedge clk);
    end
    chk("ovf_drained", 64'(out_valid), 64'd0);
    chk("ovf_drop_after", 64'(drop_count), 64'd1);

    do_reset();
    idx = 0;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      out_ready = (i >= 5);
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d", idx), 64'(out_pc), 64'(32'h300 + 4 * idx));
        idx++;
      end
      imem_req_valid = (i < 13);
      imem_req_addr = 32'h300 + 4 * i;
      imem_resp_data = tv[i % 14].data;
    end
    chk("stream_count", 64'(idx), 64'd13);
    chk("stream_drop", 64'(drop_count), 64'd0);
    chk("stream_ovf", 64'(overflow), 64'd0);
    chk("stream_fetch", 64'(fetch_count), 64'd13);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_req_valid = 1'b1; imem_req_addr = 32'h400 + 4 * i; imem_resp_data = tv[1].data;
    end
    @(negedge clk);
    imem_req_valid = 1'b0;
    chk("pre_areset_valid", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_valid", 64'(out_valid), 64'd0);
    chk("areset_stats", {overflow, fetch_count, drop_count}, 64'd0);
    chk("areset_fields", {out_pc, act_fields()}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("areset_discard", 64'(out_valid), 64'd0);

    do_reset();
    cnt = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
      imem_req_valid = (k < 3);
      imem_req_addr = 32'h8;
      imem_resp_data = tv[0].data;
    end
`ifdef TRACE_FILTER_DUP_EN
    chk("dup_fetch", 64'(fetch_count), 64'd1);
    chk("dup_entries", 64'(cnt), 64'd1);
`else
    chk("dup_fetch", 64'(fetch_count), 64'd3);
    chk("dup_entries", 64'(cnt), 64'd3);
`endif

    do_reset();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      imem_req_valid = 1'b1; imem_req_addr = 32'h800 + 4 * i; imem_resp_data = tv[4].data;
    end
    @(negedge clk);
    imem_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sat_fetch", 64'(fetch_count), 64'd15);
    chk("sat_drop", 64'(drop_count), 64'd15);
    chk("sat_ovf", 64'(overflow), 64'd1);
    chk("sat_head", 64'(out_pc), 64'h800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
